// File: rtl/parameters.sv
// Shared decoder-stage encodings plus the loader's decoder-tracking states and size helpers.
package parameters;
    localparam int STAGE_WIDTH = 3;

    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
    localparam logic [STAGE_WIDTH-1:0] STAGE_GROWING             = 3'd2;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MERGING             = 3'd3;
    localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd4;
    localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd5;

    localparam logic [1:0] DEC_FREE     = 2'd0;
    localparam logic [1:0] DEC_STARTING = 2'd1;
    localparam logic [1:0] DEC_BUSY     = 2'd2;

    function automatic int pu_count(input int dist_x, input int dist_z);
        return dist_x * dist_z * ((dist_x > dist_z) ? dist_x : dist_z);
    endfunction

    function automatic int words_per_round(input int pu, input int width);
        return (pu + width - 1) / width;
    endfunction
endpackage

// File: rtl/syndrome_round_loader_round_word_assembler.sv
// Collects one round of stream words into the fill buffer; rejects rounds whose
// s_last does not land on the final word, resynchronising on a missing s_last.
module round_word_assembler
    import parameters::*;
#(
    parameter int INPUT_WIDTH = 64,
    parameter int PU_COUNT    = 576
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INPUT_WIDTH-1:0] s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    input  logic                   clear,
    output logic [PU_COUNT-1:0]    fill,
    output logic                   fill_full,
    output logic                   length_error
);
    localparam int WORDS = words_per_round(PU_COUNT, INPUT_WIDTH);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    logic [INPUT_WIDTH-1:0]       words [WORDS];
    logic [WORDS*INPUT_WIDTH-1:0] flat;
    logic [IDX_W-1:0]             word_idx;
    logic                         resync;
    logic                         xfer;

    assign s_ready = !fill_full && !reset;
    assign xfer    = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < WORDS; k++) words[k] <= '0;
            word_idx     <= '0;
            fill_full    <= 1'b0;
            resync       <= 1'b0;
            length_error <= 1'b0;
        end else begin
            if (clear) fill_full <= 1'b0;
            if (xfer) begin
                // While resynchronising, everything through the next s_last is junk.
                if (resync) begin
                    if (s_last) resync <= 1'b0;
                end else begin
                    words[word_idx] <= s_data;
                    if (word_idx == LAST_IDX) begin
                        word_idx <= '0;
                        if (s_last) begin
                            fill_full <= 1'b1;
                        end else begin
                            length_error <= 1'b1;
                            resync       <= 1'b1;
                        end
                    end else if (s_last) begin
                        word_idx     <= '0;
                        length_error <= 1'b1;
                    end else begin
                        word_idx <= word_idx + IDX_W'(1);
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < WORDS; k++) begin : g_flat
        assign flat[k*INPUT_WIDTH +: INPUT_WIDTH] = words[k];
    end

    assign fill = flat[PU_COUNT-1:0];
endmodule

// File: rtl/syndrome_round_loader.sv
// Feeds assembled syndrome rounds to the decoder, launching one only when the decoder is free.
//   state        | meaning
//   DEC_FREE     | decoder idle; launch as soon as a full round is buffered
//   DEC_STARTING | launched; waiting for the decoder to leave IDLE
//   DEC_BUSY     | decoding; IDLE with result_valid or deadlock ends it
module syndrome_round_loader
    import parameters::*;
#(
    parameter int  CODE_DISTANCE_X = 4,
    parameter int  CODE_DISTANCE_Z = 12,
    parameter int  INPUT_WIDTH     = 64,
    localparam int PU_COUNT        = pu_count(CODE_DISTANCE_X, CODE_DISTANCE_Z)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INPUT_WIDTH-1:0] s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    input  logic [STAGE_WIDTH-1:0] stage,
    input  logic                   result_valid,
    input  logic                   deadlock,
    output logic                   new_round_start,
    output logic [PU_COUNT-1:0]    measurements,
    output logic [31:0]            round_count,
    output logic                   length_error
);
    logic [1:0]          dec_state;
    logic [PU_COUNT-1:0] fill;
    logic                fill_full;
    logic                launch;

    assign launch = (dec_state == DEC_FREE) && fill_full && (stage == STAGE_IDLE);

    round_word_assembler #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .PU_COUNT    (PU_COUNT)
    ) u_assembler (
        .clk          (clk),
        .reset        (reset),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .clear        (launch),
        .fill         (fill),
        .fill_full    (fill_full),
        .length_error (length_error)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            dec_state       <= DEC_FREE;
            new_round_start <= 1'b0;
            measurements    <= '0;
            round_count     <= '0;
        end else begin
            new_round_start <= 1'b0;
            case (dec_state)
                DEC_FREE: begin
                    if (launch) begin
                        measurements    <= fill;
                        new_round_start <= 1'b1;
                        round_count     <= round_count + 32'd1;
                        dec_state       <= DEC_STARTING;
                    end
                end
                // Completion flags left over from the previous round are ignored here.
                DEC_STARTING: if (stage != STAGE_IDLE) dec_state <= DEC_BUSY;
                DEC_BUSY: begin
                    if (stage == STAGE_IDLE && (result_valid || deadlock)) dec_state <= DEC_FREE;
                end
                default: dec_state <= DEC_FREE;
            endcase
        end
    end
endmodule

// File: tb/tb_syndrome_round_loader.sv
// Randomized self-checking bench for syndrome_round_loader against a round-level model.
module tb_syndrome_round_loader;
    import parameters::*;

    localparam int DX  = 4;
    localparam int DZ  = 12;
    localparam int IW  = 64;
    localparam int PU  = DX * DZ * ((DX > DZ) ? DX : DZ);
    localparam int WPR = (PU + IW - 1) / IW;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [IW-1:0]          s_data = '0;
    logic                   s_valid = 1'b0;
    logic                   s_last = 1'b0;
    logic                   s_ready;
    logic [STAGE_WIDTH-1:0] stage = STAGE_IDLE;
    logic                   result_valid = 1'b0;
    logic                   deadlock = 1'b0;
    logic                   new_round_start;
    logic [PU-1:0]          measurements;
    logic [31:0]            round_count;
    logic                   length_error;

    syndrome_round_loader #(
        .CODE_DISTANCE_X (DX),
        .CODE_DISTANCE_Z (DZ),
        .INPUT_WIDTH     (IW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_last          (s_last),
        .s_ready         (s_ready),
        .stage           (stage),
        .result_valid    (result_valid),
        .deadlock        (deadlock),
        .new_round_start (new_round_start),
        .measurements    (measurements),
        .round_count     (round_count),
        .length_error    (length_error)
    );

    always #5 clk = ~clk;

    int            compared = 0;
    int            mismatched = 0;
    int            pulses = 0;
    int            exp_rc = 0;
    bit            timed_out = 1'b0;
    logic [IW-1:0] rw [WPR];
    logic [PU-1:0] exp_vec;
    logic [PU-1:0] prev_vec;

    always @(posedge clk) if (new_round_start === 1'b1) pulses <= pulses + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Random round and its expected measurement vector (word k at bits k*IW.., clipped to PU).
    task automatic gen_round();
        for (int k = 0; k < WPR; k++) rw[k] = {$urandom, $urandom};
        exp_vec = '0;
        for (int k = 0; k < WPR; k++)
            for (int b = 0; b < IW; b++)
                if (k * IW + b < PU) exp_vec[k*IW+b] = rw[k][b];
    endtask

    // Called at a negedge; returns at the negedge following the transfer edge.
    task automatic send_word(input logic [IW-1:0] d, input bit last);
        int budget;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        s_data = d; s_valid = 1'b1; s_last = last;
        budget = 200;
        while (s_ready !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) timed_out = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_round(input int n, input int last_at);
        for (int k = 0; k < n; k++) send_word(rw[k], k == last_at);
    endtask

    task automatic wait_pulse(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (new_round_start === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic finish_decode();
        stage = STAGE_GROWING;
        repeat (2) @(negedge clk);
        stage = STAGE_IDLE; result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_rc = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        compared++; if (s_ready !== 1'b0) begin mismatched++; $display("FAIL reset_s_ready: got %0b expected 0", s_ready); end
        compared++; if (new_round_start !== 1'b0) begin mismatched++; $display("FAIL reset_pulse: got %0b expected 0", new_round_start); end
        compared++; if (measurements !== '0) begin mismatched++; $display("FAIL reset_meas: got %0h expected 0", measurements); end
        compared++; if (round_count !== 32'd0) begin mismatched++; $display("FAIL reset_rc: got %0d expected 0", round_count); end
        compared++; if (length_error !== 1'b0) begin mismatched++; $display("FAIL reset_lenerr: got %0b expected 0", length_error); end
        reset = 1'b0;
        exp_rc = 0;
        @(negedge clk);
        compared++; if (s_ready !== 1'b1) begin mismatched++; $display("FAIL reset_release_ready: got %0b expected 1", s_ready); end
    endtask

    task automatic test_single_round();
        gen_round();
        send_round(WPR - 1, -1);
        send_word(rw[WPR-1], 1'b1);
        compared++; if (s_ready !== 1'b0) begin mismatched++; $display("FAIL single_ready_low: got %0b expected 0", s_ready); end
        compared++; if (new_round_start !== 1'b0) begin mismatched++; $display("FAIL single_early_pulse: got %0b expected 0", new_round_start); end
        @(negedge clk);
        exp_rc++;
        compared++; if (new_round_start !== 1'b1) begin mismatched++; $display("FAIL single_latency: got %0b expected 1", new_round_start); end
        compared++; if (measurements !== exp_vec) begin mismatched++; $display("FAIL single_meas: got %0h expected %0h", measurements, exp_vec); end
        compared++; if (measurements[IW-1:0] !== rw[0]) begin mismatched++; $display("FAIL single_word0: got %0h expected %0h", measurements[IW-1:0], rw[0]); end
        compared++; if (round_count !== 32'(exp_rc)) begin mismatched++; $display("FAIL single_rc: got %0d expected %0d", round_count, exp_rc); end
        @(negedge clk);
        compared++; if (new_round_start !== 1'b0) begin mismatched++; $display("FAIL single_pulse_width: got %0b expected 0", new_round_start); end
        compared++; if (s_ready !== 1'b1) begin mismatched++; $display("FAIL single_ready_back: got %0b expected 1", s_ready); end
        compared++; if (timed_out !== 1'b0) begin mismatched++; $display("FAIL single_timeout: got %0b expected 0", timed_out); end
        prev_vec = exp_vec;
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pulses;
        stage = STAGE_GROWING;
        gen_round();
        send_round(WPR, WPR - 1);
        repeat (5) @(negedge clk);
        compared++; if (pulses !== p0) begin mismatched++; $display("FAIL b2b_held_pulses: got %0d expected %0d", pulses, p0); end
        compared++; if (measurements !== prev_vec) begin mismatched++; $display("FAIL b2b_meas_stable: got %0h expected %0h", measurements, prev_vec); end
        compared++; if (s_ready !== 1'b0) begin mismatched++; $display("FAIL b2b_ready_held: got %0b expected 0", s_ready); end
        stage = STAGE_IDLE; result_valid = 1'b1;
        @(negedge clk);
        compared++; if (new_round_start !== 1'b0) begin mismatched++; $display("FAIL b2b_pulse_early: got %0b expected 0", new_round_start); end
        @(negedge clk);
        exp_rc++;
        compared++; if (new_round_start !== 1'b1) begin mismatched++; $display("FAIL b2b_pulse: got %0b expected 1", new_round_start); end
        compared++; if (measurements !== exp_vec) begin mismatched++; $display("FAIL b2b_meas: got %0h expected %0h", measurements, exp_vec); end
        compared++; if (round_count !== 32'(exp_rc)) begin mismatched++; $display("FAIL b2b_rc: got %0d expected %0d", round_count, exp_rc); end
        result_valid = 1'b0;
        finish_decode();
        compared++; if (timed_out !== 1'b0) begin mismatched++; $display("FAIL b2b_timeout: got %0b expected 0", timed_out); end
    endtask

    task automatic test_stale_completion();
        int            p0;
        bit            found;
        logic [PU-1:0] vec_c;
        p0 = pulses;
        result_valid = 1'b1;
        gen_round();
        send_round(WPR, WPR - 1);
        wait_pulse(10, found);
        exp_rc++;
        compared++; if (found !== 1'b1) begin mismatched++; $display("FAIL stale_first_pulse: got %0b expected 1", found); end
        compared++; if (measurements !== exp_vec) begin mismatched++; $display("FAIL stale_meas_c: got %0h expected %0h", measurements, exp_vec); end
        vec_c = exp_vec;
        gen_round();
        send_round(WPR, WPR - 1);
        repeat (6) @(negedge clk);
        compared++; if (pulses !== p0 + 1) begin mismatched++; $display("FAIL stale_no_second_pulse: got %0d expected %0d", pulses, p0 + 1); end
        compared++; if (measurements !== vec_c) begin mismatched++; $display("FAIL stale_meas_hold: got %0h expected %0h", measurements, vec_c); end
        stage = STAGE_GROWING;
        repeat (2) @(negedge clk);
        stage = STAGE_IDLE;
        wait_pulse(10, found);
        exp_rc++;
        compared++; if (found !== 1'b1) begin mismatched++; $display("FAIL stale_second_pulse: got %0b expected 1", found); end
        compared++; if (measurements !== exp_vec) begin mismatched++; $display("FAIL stale_meas_d: got %0h expected %0h", measurements, exp_vec); end
        compared++; if (round_count !== 32'(exp_rc)) begin mismatched++; $display("FAIL stale_rc: got %0d expected %0d", round_count, exp_rc); end
        result_valid = 1'b0;
        finish_decode();
        compared++; if (pulses !== p0 + 2) begin mismatched++; $display("FAIL stale_pulse_total: got %0d expected %0d", pulses, p0 + 2); end
    endtask

    task automatic test_missing_last();
        int p0;
        bit found;
        pulse_reset();
        compared++; if (length_error !== 1'b0) begin mismatched++; $display("FAIL missing_lenerr_clear: got %0b expected 0", length_error); end
        p0 = pulses;
        gen_round();
        send_round(WPR, -1);
        for (int j = 0; j < 3; j++) send_word({$urandom, $urandom}, j == 2);
        repeat (4) @(negedge clk);
        compared++; if (length_error !== 1'b1) begin mismatched++; $display("FAIL missing_lenerr: got %0b expected 1", length_error); end
        compared++; if (pulses !== p0) begin mismatched++; $display("FAIL missing_no_launch: got %0d expected %0d", pulses, p0); end
        compared++; if (s_ready !== 1'b1) begin mismatched++; $display("FAIL missing_ready: got %0b expected 1", s_ready); end
        gen_round();
        send_round(WPR, WPR - 1);
        wait_pulse(10, found);
        exp_rc++;
        compared++; if (found !== 1'b1) begin mismatched++; $display("FAIL missing_next_pulse: got %0b expected 1", found); end
        compared++; if (measurements !== exp_vec) begin mismatched++; $display("FAIL missing_next_meas: got %0h expected %0h", measurements, exp_vec); end
        compared++; if (round_count !== 32'(exp_rc)) begin mismatched++; $display("FAIL missing_rc: got %0d expected %0d", round_count, exp_rc); end
        finish_decode();
    endtask

    task automatic test_early_last();
        int p0;
        bit found;
        pulse_reset();
        p0 = pulses;
        gen_round();
        send_round(5, 4);
        repeat (4) @(negedge clk);
        compared++; if (length_error !== 1'b1) begin mismatched++; $display("FAIL early_lenerr: got %0b expected 1", length_error); end
        compared++; if (pulses !== p0) begin mismatched++; $display("FAIL early_no_launch: got %0d expected %0d", pulses, p0); end
        compared++; if (s_ready !== 1'b1) begin mismatched++; $display("FAIL early_ready: got %0b expected 1", s_ready); end
        gen_round();
        send_round(WPR, WPR - 1);
        wait_pulse(10, found);
        exp_rc++;
        compared++; if (found !== 1'b1) begin mismatched++; $display("FAIL early_next_pulse: got %0b expected 1", found); end
        compared++; if (measurements !== exp_vec) begin mismatched++; $display("FAIL early_next_meas: got %0h expected %0h", measurements, exp_vec); end
        compared++; if (round_count !== 32'(exp_rc)) begin mismatched++; $display("FAIL early_rc: got %0d expected %0d", round_count, exp_rc); end
        finish_decode();
    endtask

    task automatic test_deadlock();
        int p0;
        bit found;
        p0 = pulses;
        gen_round();
        send_round(WPR, WPR - 1);
        wait_pulse(10, found);
        exp_rc++;
        compared++; if (found !== 1'b1) begin mismatched++; $display("FAIL dl_first_pulse: got %0b expected 1", found); end
        stage = STAGE_GROWING;
        gen_round();
        send_round(WPR, WPR - 1);
        repeat (3) @(negedge clk);
        compared++; if (pulses !== p0 + 1) begin mismatched++; $display("FAIL dl_pending_held: got %0d expected %0d", pulses, p0 + 1); end
        stage = STAGE_IDLE; deadlock = 1'b1; result_valid = 1'b0;
        @(negedge clk);
        compared++; if (new_round_start !== 1'b0) begin mismatched++; $display("FAIL dl_pulse_early: got %0b expected 0", new_round_start); end
        @(negedge clk);
        exp_rc++;
        compared++; if (new_round_start !== 1'b1) begin mismatched++; $display("FAIL dl_pulse: got %0b expected 1", new_round_start); end
        compared++; if (measurements !== exp_vec) begin mismatched++; $display("FAIL dl_meas: got %0h expected %0h", measurements, exp_vec); end
        compared++; if (round_count !== 32'(exp_rc)) begin mismatched++; $display("FAIL dl_rc: got %0d expected %0d", round_count, exp_rc); end
        deadlock = 1'b0;
        finish_decode();
    endtask

    task automatic test_reset_mid_fill();
        bit found;
        gen_round();
        send_round(4, -1);
        reset = 1'b1;
        @(negedge clk);
        compared++; if (s_ready !== 1'b0) begin mismatched++; $display("FAIL midrst_ready: got %0b expected 0", s_ready); end
        compared++; if (measurements !== '0) begin mismatched++; $display("FAIL midrst_meas: got %0h expected 0", measurements); end
        compared++; if (round_count !== 32'd0) begin mismatched++; $display("FAIL midrst_rc: got %0d expected 0", round_count); end
        compared++; if (length_error !== 1'b0) begin mismatched++; $display("FAIL midrst_lenerr: got %0b expected 0", length_error); end
        reset = 1'b0;
        exp_rc = 0;
        @(negedge clk);
        gen_round();
        send_round(WPR, WPR - 1);
        wait_pulse(10, found);
        exp_rc++;
        compared++; if (found !== 1'b1) begin mismatched++; $display("FAIL midrst_pulse: got %0b expected 1", found); end
        compared++; if (round_count !== 32'd1) begin mismatched++; $display("FAIL midrst_rc_after: got %0d expected 1", round_count); end
        compared++; if (measurements !== exp_vec) begin mismatched++; $display("FAIL midrst_meas_after: got %0h expected %0h", measurements, exp_vec); end
        compared++; if (timed_out !== 1'b0) begin mismatched++; $display("FAIL overall_timeout: got %0b expected 0", timed_out); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_round();
        test_back_to_back();
        test_stale_completion();
        test_missing_last();
        test_early_last();
        test_deadlock();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
